// File: rtl/trace_pkg.sv
// Shared encodings for the trace capture / UART dump block.
package trace_pkg;

    typedef enum logic [1:0] {
        ARMED = 2'd0,
        POST  = 2'd1,
        DUMP  = 2'd2,
        DONE  = 2'd3
    } trace_state_e;

    localparam logic [7:0] HDR_BYTE   = 8'hA5;
    localparam int         FRAME_BITS = 10;

endpackage

// File: rtl/trace_uart_dump_uart_tx.sv
// 8N1 UART transmitter: one byte per frame, frames may be issued back-to-back.
module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_valid,
    input  logic [7:0] i_byte,
    output logic       o_ready,
    output logic       o_tx
);
    import trace_pkg::*;

    localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  LAST_CLK = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]        LAST_BIT = 4'(FRAME_BITS - 1);

    logic                  r_busy;
    logic [FRAME_BITS-1:0] r_shift;
    logic [CNT_W-1:0]      r_clk_cnt;
    logic [3:0]            r_bit_cnt;
    logic                  w_bit_end;
    logic                  w_accept;

    // Handshake: a byte transfers on any cycle with i_valid && o_ready. o_ready is
    // also high on the final stop-bit cycle so the next start bit follows with no gap.
    assign w_bit_end = (r_clk_cnt == LAST_CLK);
    assign o_ready   = ~r_busy | (w_bit_end & (r_bit_cnt == LAST_BIT));
    assign w_accept  = i_valid & o_ready;
    assign o_tx      = r_shift[0];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_busy    <= 1'b0;
            r_shift   <= '1;
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
        end else if (w_accept) begin
            r_busy    <= 1'b1;
            r_shift   <= {1'b1, i_byte, 1'b0};
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
        end else if (r_busy) begin
            if (w_bit_end) begin
                r_clk_cnt <= '0;
                // Shift in ones so the line rests high once the frame is out.
                r_shift   <= {1'b1, r_shift[FRAME_BITS-1:1]};
                if (r_bit_cnt == LAST_BIT) begin
                    r_busy    <= 1'b0;
                    r_bit_cnt <= '0;
                end else begin
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                end
            end else begin
                r_clk_cnt <= r_clk_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/trace_uart_dump.sv
// Trace capture with pre-trigger history; frozen buffer is streamed out as 8N1 UART bytes.
module trace_uart_dump #(
    parameter int DATA_W   = 6,
    parameter int DEPTH    = 64,
    parameter int PRE_TRIG = 16,
    parameter int CLK_HZ   = 27000000,
    parameter int BAUD     = 115200
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_trigger,
    input  logic              i_arm,
    output logic              o_uart_tx,
    output logic              o_busy,
    output logic              o_done
);
    import trace_pkg::*;

    localparam int              CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int              AW           = $clog2(DEPTH);
    localparam int              CW           = $clog2(DEPTH + 2);
    localparam logic [AW-1:0]   PRE_PTR      = AW'(PRE_TRIG);
    localparam logic [AW-1:0]   POST_LOAD    = AW'(DEPTH - PRE_TRIG - 1);
    localparam logic [CW-1:0]   LAST_CNT     = CW'(DEPTH + 1);

    trace_state_e      r_state;
    trace_state_e      w_next;
    logic              r_trig_q;
    logic              w_edge;
    logic              w_fire;
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_fill;
    logic [AW-1:0]     r_post_cnt;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_byte_cnt;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_data;
    logic              w_we;
    logic              w_tx_valid;
    logic              w_tx_ready;
    logic              w_tx_accept;
    logic [7:0]        w_tx_byte;

    assign w_edge      = i_trigger & ~r_trig_q;
    assign w_fire      = (r_state == ARMED) && w_edge && (r_fill == PRE_PTR);
    assign w_we        = (r_state == ARMED) || (r_state == POST);
    // r_byte_cnt counts accepted bytes; count 0 is the header.
    assign w_tx_valid  = (r_state == DUMP) && (r_byte_cnt != LAST_CNT);
    assign w_tx_byte   = (r_byte_cnt == '0) ? HDR_BYTE : 8'(r_rd_data);
    assign w_tx_accept = w_tx_valid & w_tx_ready;
    assign o_busy      = (r_state == POST) || (r_state == DUMP);
    assign o_done      = (r_state == DONE);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ARMED;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ARMED:   if (w_fire) w_next = (POST_LOAD == '0) ? DUMP : POST;
            POST:    if (r_post_cnt == AW'(1)) w_next = DUMP;
            DUMP:    if ((r_byte_cnt == LAST_CNT) && w_tx_ready) w_next = DONE;
            DONE:    if (i_arm) w_next = ARMED;
            default: w_next = ARMED;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_trig_q   <= 1'b0;
            r_wr_ptr   <= '0;
            r_fill     <= '0;
            r_post_cnt <= '0;
            r_rd_ptr   <= '0;
            r_byte_cnt <= '0;
        end else begin
            r_trig_q <= i_trigger;
            case (r_state)
                ARMED: begin
                    r_wr_ptr   <= r_wr_ptr + AW'(1);
                    r_byte_cnt <= '0;
                    if (r_fill != PRE_PTR) r_fill <= r_fill + AW'(1);
                    if (w_fire) begin
                        // Oldest kept sample sits PRE_TRIG slots behind the trigger sample.
                        r_rd_ptr   <= r_wr_ptr - PRE_PTR;
                        r_post_cnt <= POST_LOAD;
                    end
                end
                POST: begin
                    r_wr_ptr   <= r_wr_ptr + AW'(1);
                    r_post_cnt <= r_post_cnt - AW'(1);
                end
                DUMP: begin
                    if (w_tx_accept) begin
                        r_byte_cnt <= r_byte_cnt + CW'(1);
                        // Advance once a sample byte is taken so the next read lands a frame early.
                        if (r_byte_cnt != '0) r_rd_ptr <= r_rd_ptr + AW'(1);
                    end
                end
                DONE: begin
                    if (i_arm) begin
                        r_wr_ptr <= '0;
                        r_fill   <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Plain synchronous-read array so it maps onto block RAM.
    always_ff @(posedge i_clk) begin
        if (w_we) r_mem[r_wr_ptr] <= i_data;
        r_rd_data <= r_mem[r_rd_ptr];
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_valid(w_tx_valid),
        .i_byte (w_tx_byte),
        .o_ready(w_tx_ready),
        .o_tx   (o_uart_tx)
    );

endmodule

// File: tb/tb_trace_uart_dump.sv
// Bench for trace_uart_dump: directed captures; a UART monitor decodes frames against an expected-byte queue.
module tb_trace_uart_dump;
    import trace_pkg::*;

    localparam int DATA_W   = 6;
    localparam int DEPTH    = 8;
    localparam int PRE_TRIG = 2;
    localparam int CLK_HZ   = 400;
    localparam int BAUD     = 100;
    localparam int CPB      = CLK_HZ / BAUD;
    localparam int FRAME    = 10 * CPB;

    typedef logic [7:0] vec_t [9];

    logic              clk = 1'b0;
    logic              i_rst = 1'b1;
    logic [DATA_W-1:0] i_data = '0;
    logic              i_trigger = 1'b0;
    logic              i_arm = 1'b0;
    logic              o_uart_tx;
    logic              o_busy;
    logic              o_done;

    int         n_tests = 0;
    int         n_fail = 0;
    int         frames_rx = 0;
    int         hdr_start_c = 0;
    int         last_start_c = 0;
    int         cyc_abs = 0;
    int         cyc_in = 0;
    logic [7:0] exp_q [$];

    vec_t exp1 = '{8'hA5, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F};
    vec_t exp2 = '{8'hA5, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A};
    vec_t exp4 = '{8'hA5, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28, 8'h29, 8'h2A, 8'h2B};

    trace_uart_dump #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .PRE_TRIG(PRE_TRIG), .CLK_HZ(CLK_HZ), .BAUD(BAUD)
    ) dut (
        .i_clk    (clk),
        .i_rst    (i_rst),
        .i_data   (i_data),
        .i_trigger(i_trigger),
        .i_arm    (i_arm),
        .o_uart_tx(o_uart_tx),
        .o_busy   (o_busy),
        .o_done   (o_done)
    );

    // ---------------- clock / reset ----------------
    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc_abs <= cyc_abs + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic run_cycle(input logic trig, input logic arm);
        i_data    = 6'(cyc_in);
        i_trigger = trig;
        i_arm     = arm;
        @(posedge clk);
        #1;
        cyc_in++;
        i_arm = 1'b0;
    endtask

    task automatic do_reset();
        i_rst     = 1'b1;
        i_trigger = 1'b0;
        i_arm     = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        i_rst  = 1'b0;
        cyc_in = 0;
    endtask

    task automatic push_vec(input vec_t v);
        for (int i = 0; i < 9; i++) exp_q.push_back(v[i]);
    endtask

    task automatic run_until_done(input int budget, input logic pulse_mode, output int done_c);
        done_c = -1;
        for (int i = 0; i < budget; i++) begin
            run_cycle(pulse_mode ? ((cyc_in % 7) < 2) : 1'b0, 1'b0);
            if (o_done) begin
                done_c = cyc_abs;
                break;
            end
        end
        check("done_reached", 32'(done_c >= 0), 32'd1);
    endtask

    task automatic trigger_at_10();
        for (int i = 0; i < 10; i++) run_cycle(1'b0, 1'b0);
        run_cycle(1'b1, 1'b0);
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin : uart_mon
        logic [9:0] bits;
        logic       ok;
        logic       aborted;
        logic [7:0] exp_b;
        int         start_c;
        forever begin
            @(negedge clk);
            if (!i_rst && o_uart_tx === 1'b0) begin
                start_c = cyc_abs;
                ok      = 1'b1;
                aborted = 1'b0;
                bits    = '0;
                for (int b = 0; b < 10 && !aborted; b++) begin
                    for (int c = 0; c < CPB && !aborted; c++) begin
                        if (b != 0 || c != 0) @(negedge clk);
                        if (i_rst) aborted = 1'b1;
                        else if (c == 0) bits[b] = o_uart_tx;
                        else if (o_uart_tx !== bits[b]) ok = 1'b0;
                    end
                end
                if (!aborted) begin
                    frames_rx++;
                    check("bit_timing", {29'd0, bits[0], bits[9], ok}, 32'd3);
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_byte: got %02h expected none", bits[8:1]);
                    end else begin
                        exp_b = exp_q.pop_front();
                        check("uart_byte", 32'(bits[8:1]), 32'(exp_b));
                        if (exp_b == HDR_BYTE) hdr_start_c = start_c;
                        else check("byte_gap", 32'(start_c - last_start_c), 32'(FRAME));
                    end
                    last_start_c = start_c;
                end
            end
        end
    end

    // ---------------- directed tests ----------------
    initial begin : main
        int dc;
        int f0;
        int bad_idle;

        // Test 1: basic capture, trigger at sample 10
        do_reset();
        check("rst_tx", 32'(o_uart_tx), 32'd1);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        check("rst_state", 32'(dut.r_state), 32'(ARMED));
        push_vec(exp1);
        trigger_at_10();
        check("busy_in_post", 32'(o_busy), 32'd1);
        check("done_in_post", 32'(o_done), 32'd0);
        run_until_done(600, 1'b0, dc);
        check("dump_cycles", 32'(dc - hdr_start_c), 32'd360);
        check("t1_queue_empty", 32'(exp_q.size()), 32'd0);
        check("done_tx_idle", 32'(o_uart_tx), 32'd1);
        check("done_not_busy", 32'(o_busy), 32'd0);

        // Test 2: early edge lost while history not full
        do_reset();
        push_vec(exp2);
        run_cycle(1'b0, 1'b0);
        run_cycle(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) run_cycle(1'b0, 1'b0);
        check("early_edge_ignored", 32'(o_busy), 32'd0);
        run_cycle(1'b1, 1'b0);
        run_until_done(600, 1'b0, dc);
        check("t2_queue_empty", 32'(exp_q.size()), 32'd0);

        // Test 3: trigger held high then pulsed through POST/DUMP/DONE
        do_reset();
        push_vec(exp1);
        f0 = frames_rx;
        for (int i = 0; i < 10; i++) run_cycle(1'b0, 1'b0);
        for (int i = 0; i < 31; i++) run_cycle(1'b1, 1'b0);
        run_until_done(600, 1'b1, dc);
        check("t3_frames", 32'(frames_rx - f0), 32'd9);
        for (int i = 0; i < 60; i++) run_cycle((cyc_in % 7) < 2, 1'b0);
        check("t3_frames_after", 32'(frames_rx - f0), 32'd9);
        check("t3_still_done", 32'(o_done), 32'd1);

        // Test 4: arm ignored mid-dump, honoured in DONE
        do_reset();
        push_vec(exp1);
        trigger_at_10();
        for (int i = 0; i < 60; i++) run_cycle(1'b0, 1'b0);
        run_cycle(1'b0, 1'b1);
        check("arm_in_dump_ignored", 32'(o_busy), 32'd1);
        run_until_done(600, 1'b0, dc);
        check("t4a_queue_empty", 32'(exp_q.size()), 32'd0);
        push_vec(exp4);
        cyc_in = 'h20;
        run_cycle(1'b0, 1'b1);
        check("rearm_done_low", 32'(o_done), 32'd0);
        check("rearm_state", 32'(dut.r_state), 32'(ARMED));
        for (int i = 0; i < 5; i++) run_cycle(1'b0, 1'b0);
        run_cycle(1'b1, 1'b0);
        run_until_done(600, 1'b0, dc);
        check("t4b_queue_empty", 32'(exp_q.size()), 32'd0);

        // Test 5: reset in the middle of byte 3
        do_reset();
        push_vec(exp1);
        f0 = frames_rx;
        trigger_at_10();
        for (int i = 0; i < 400 && (frames_rx - f0) < 3; i++) run_cycle(1'b0, 1'b0);
        check("t5_three_frames", 32'(frames_rx - f0), 32'd3);
        for (int i = 0; i < 15; i++) run_cycle(1'b0, 1'b0);
        i_rst = 1'b1;
        run_cycle(1'b0, 1'b0);
        i_rst = 1'b0;
        check("rst_mid_tx", 32'(o_uart_tx), 32'd1);
        check("rst_mid_state", 32'(dut.r_state), 32'(ARMED));
        check("rst_mid_busy", 32'(o_busy), 32'd0);
        exp_q.delete();
        f0 = frames_rx;
        bad_idle = 0;
        for (int i = 0; i < 200; i++) begin
            run_cycle(1'b0, 1'b0);
            if (o_uart_tx !== 1'b1) bad_idle++;
        end
        check("idle_after_rst", 32'(bad_idle), 32'd0);
        check("no_frames_after_rst", 32'(frames_rx - f0), 32'd0);
        push_vec(exp1);
        cyc_in = 0;
        trigger_at_10();
        run_until_done(600, 1'b0, dc);
        check("t5_queue_empty", 32'(exp_q.size()), 32'd0);
        check("t5_frames", 32'(frames_rx - f0), 32'd9);

        repeat (5) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
